// File: rtl/mult_share_pkg.sv
// Shared definitions for the mult_share arbiter: FSM state encoding and index-width helper.
package mult_share_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_ARM    = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult.sv
// Sequential shift-add multiplier, one multiplier bit per cycle; the multiplier MSB is
// subtracted when the multiplier is signed so both operands behave as two's complement.
module mult #(
  parameter int BW_CNT   = 3,
  parameter int BW_MCAND = 3,
  parameter int BW_MLIER = 4
) (
  input  logic                         clk,
  input  logic                         rstx,
  input  logic                         start,
  input  logic                         mcand_signed,
  input  logic                         mlier_signed,
  input  logic [BW_MCAND-1:0]          mcand,
  input  logic [BW_MLIER-1:0]          mlier,
  output logic                         busy,
  output logic [BW_MCAND+BW_MLIER-1:0] prod
);
  localparam int BW_P = BW_MCAND + BW_MLIER;

  logic              busy_q;
  logic [BW_CNT-1:0] cnt_q;
  logic [BW_P-1:0]   acc_q;
  logic [BW_P-1:0]   acc_d;
  logic [BW_P-1:0]   mc_q;
  logic [BW_MLIER-1:0] ml_q;
  logic              mls_q;
  logic [BW_P-1:0]   prod_q;
  logic [BW_P-1:0]   term;
  logic              last;

  always_comb begin
    last  = (cnt_q == BW_CNT'(BW_MLIER - 1));
    term  = ml_q[0] ? (mc_q << cnt_q) : '0;
    acc_d = (last && mls_q) ? acc_q - term : acc_q + term;
  end

  always_ff @(posedge clk) begin
    if (!rstx) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      mc_q   <= '0;
      ml_q   <= '0;
      mls_q  <= 1'b0;
      prod_q <= '0;
    end else if (!busy_q) begin
      if (start) begin
        busy_q <= 1'b1;
        cnt_q  <= '0;
        acc_q  <= '0;
        mc_q   <= {{(BW_P-BW_MCAND){mcand_signed & mcand[BW_MCAND-1]}}, mcand};
        ml_q   <= mlier;
        mls_q  <= mlier_signed;
      end
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + BW_CNT'(1);
      ml_q  <= ml_q >> 1;
      if (last) begin
        busy_q <= 1'b0;
        prod_q <= acc_d;
      end
    end
  end

  assign busy = busy_q;
  assign prod = prod_q;

endmodule

// File: rtl/mult_share_rr_arb.sv
// Round-robin arbiter: first request at or after the pointer wins; pointer moves past the winner on advance.
module mult_share_rr_arb #(
  parameter int N_REQ = 2,
  parameter int IW    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    grant_idx
);
  logic [IW-1:0] ptr_q;

  always_comb begin
    int  j;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(ptr_q) + k) % N_REQ;
      if (!found && req[j]) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IW'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + IW'(1);
    end
  end

endmodule

// File: rtl/mult_share.sv
// Shares one sequential multiplier among N_REQ requesters: round-robin accept, operand latching,
// start pulse, and routing of the finished product back to the owner as a one-cycle done strobe.
module mult_share
  import mult_share_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int BW_CNT   = 3,
  parameter int BW_MCAND = 3,
  parameter int BW_MLIER = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0]            req_mcand_signed,
  input  logic [N_REQ-1:0]            req_mlier_signed,
  input  logic [N_REQ*BW_MCAND-1:0]   req_mcand,
  input  logic [N_REQ*BW_MLIER-1:0]   req_mlier,
  output logic [N_REQ-1:0]            ack,
  output logic [N_REQ-1:0]            done,
  output logic [BW_MCAND+BW_MLIER-1:0] prod,
  output logic                        busy
);
  localparam int BW_P = BW_MCAND + BW_MLIER;
  localparam int IW   = idx_width(N_REQ);

  state_e              state_q, state_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [BW_MCAND-1:0] mcand_q, mcand_d;
  logic [BW_MLIER-1:0] mlier_q, mlier_d;
  logic                mcs_q, mcs_d, mls_q, mls_d;
  logic [N_REQ-1:0]    ack_q, ack_d, done_q, done_d;
  logic [BW_P-1:0]     prod_q, prod_d;

  logic [BW_MCAND-1:0] mcand_arr [N_REQ];
  logic [BW_MLIER-1:0] mlier_arr [N_REQ];
  logic [N_REQ-1:0]    grant;
  logic [IW-1:0]       grant_idx;
  logic                accept;
  logic                mult_busy;
  logic [BW_P-1:0]     mult_prod;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign mcand_arr[gi] = req_mcand[gi*BW_MCAND +: BW_MCAND];
    assign mlier_arr[gi] = req_mlier[gi*BW_MLIER +: BW_MLIER];
  end

  assign accept = (state_q == ST_IDLE) && (|req);

  mult_share_rr_arb #(.N_REQ(N_REQ), .IW(IW)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Reset also aborts the multiplier so a half-finished job never produces a done.
  mult #(.BW_CNT(BW_CNT), .BW_MCAND(BW_MCAND), .BW_MLIER(BW_MLIER)) u_mult (
    .clk          (clk),
    .rstx         (~rst),
    .start        (state_q == ST_LAUNCH),
    .mcand_signed (mcs_q),
    .mlier_signed (mls_q),
    .mcand        (mcand_q),
    .mlier        (mlier_q),
    .busy         (mult_busy),
    .prod         (mult_prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      mcand_q <= '0;
      mlier_q <= '0;
      mcs_q   <= 1'b0;
      mls_q   <= 1'b0;
      ack_q   <= '0;
      done_q  <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      mcand_q <= mcand_d;
      mlier_q <= mlier_d;
      mcs_q   <= mcs_d;
      mls_q   <= mls_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      prod_q  <= prod_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (|req) state_d = ST_LAUNCH;
      ST_LAUNCH: state_d = ST_ARM;
      ST_ARM:    state_d = ST_WAIT;
      ST_WAIT:   if (!mult_busy) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    owner_d = owner_q;
    mcand_d = mcand_q;
    mlier_d = mlier_q;
    mcs_d   = mcs_q;
    mls_d   = mls_q;
    ack_d   = '0;
    done_d  = '0;
    prod_d  = prod_q;
    if (accept) begin
      ack_d   = grant;
      owner_d = grant_idx;
      mcand_d = mcand_arr[grant_idx];
      mlier_d = mlier_arr[grant_idx];
      mcs_d   = req_mcand_signed[grant_idx];
      mls_d   = req_mlier_signed[grant_idx];
    end else if (state_q == ST_WAIT && !mult_busy) begin
      done_d[owner_q] = 1'b1;
      prod_d          = mult_prod;
    end
  end

  assign ack  = ack_q;
  assign done = done_q;
  assign prod = prod_q;
  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mult_share.sv
// Directed bench for mult_share (N_REQ=2, 3x4-bit operands): fixed vectors, fairness, abort, exhaustive sweep.
module tb_mult_share;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req, mcs, mls;
  logic [5:0] req_mcand;
  logic [7:0] req_mlier;
  logic [1:0] ack, done;
  logic [6:0] prod;
  logic       busy;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mult_share #(.N_REQ(2), .BW_CNT(3), .BW_MCAND(3), .BW_MLIER(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .req              (req),
    .req_mcand_signed (mcs),
    .req_mlier_signed (mls),
    .req_mcand        (req_mcand),
    .req_mlier        (req_mlier),
    .ack              (ack),
    .done             (done),
    .prod             (prod),
    .busy             (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_prod(input bit smc, input bit sml, input int mc, input int ml);
    int a, b;
    a = (smc && mc >= 4) ? mc - 8 : mc;
    b = (sml && ml >= 8) ? ml - 16 : ml;
    return (a * b) & 127;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int idx, input bit s_mc, input bit s_ml, input int mc, input int ml);
    mcs[idx] = s_mc;
    mls[idx] = s_ml;
    req_mcand[idx*3 +: 3] = mc[2:0];
    req_mlier[idx*4 +: 4] = ml[3:0];
  endtask

  task automatic wait_ack(input logic [1:0] exp, input string tag);
    int n = 0;
    while (ack == 2'b00 && n < 30) begin
      tick();
      n++;
    end
    chk({tag, "_ack"}, ack, exp);
    chk({tag, "_ack_done_excl"}, done, 0);
  endtask

  task automatic wait_done(input logic [1:0] exp, input int exp_prod, input string tag);
    int n = 0;
    while (done == 2'b00 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, done, exp);
    chk({tag, "_prod"}, prod, exp_prod);
    chk({tag, "_done_ack_excl"}, ack, 0);
    tick();
    chk({tag, "_done_clear"}, done, 0);
    chk({tag, "_busy_low"}, busy, 0);
    chk({tag, "_prod_hold"}, prod, exp_prod);
  endtask

  task automatic do_job(input int idx, input bit s_mc, input bit s_ml, input int mc, input int ml,
                        input int exp_prod, input string tag);
    logic [1:0] oh;
    oh = 2'b01 << idx;
    set_ops(idx, s_mc, s_ml, mc, ml);
    req[idx] = 1'b1;
    wait_ack(oh, tag);
    req[idx] = 1'b0;
    wait_done(oh, exp_prod, tag);
    $display("job %s: req%0d mc=%0d ml=%0d signs=%0d%0d prod=%0d", tag, idx, mc, ml, s_mc, s_ml, prod);
  endtask

  initial begin
    int sweep_idx;
    logic [1:0] who;
    int quiet;
    rst = 1'b1; req = '0; mcs = '0; mls = '0; req_mcand = '0; req_mlier = '0;
    repeat (3) tick();
    chk("rst_ack", ack, 0);
    chk("rst_done", done, 0);
    chk("rst_prod", prod, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    do_job(0, 1'b0, 1'b0, 3, 5, 15, "t1_uu");
    do_job(1, 1'b1, 1'b1, 7, 8, 8, "t2_ss");
    do_job(1, 1'b1, 1'b0, 5, 15, 83, "t3_su");

    // Both requesters held: ownership must alternate starting from requester 0.
    rst = 1'b1; tick(); rst = 1'b0;
    set_ops(0, 1'b0, 1'b0, 2, 7);
    set_ops(1, 1'b1, 1'b1, 6, 3);
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      who = (k % 2 == 0) ? 2'b01 : 2'b10;
      wait_ack(who, "t4_rr");
      wait_done(who, (k % 2 == 0) ? 14 : 122, "t4_rr");
      $display("job t4_rr: round %0d served %b prod=%0d", k, who, prod);
    end
    req = 2'b00;
    tick();

    // Abort during WAIT: no done for the dropped job.
    set_ops(0, 1'b0, 1'b0, 2, 3);
    req[0] = 1'b1;
    wait_ack(2'b01, "t5_abort");
    req[0] = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_ack", ack, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_prod", prod, 0);
    chk("t5_rst_busy", busy, 0);
    quiet = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done != 2'b00) quiet++;
    end
    chk("t5_no_done", quiet, 0);
    $display("job t5_abort: reset during WAIT, done pulses seen=%0d", quiet);
    do_job(1, 1'b0, 1'b0, 3, 2, 6, "t5_after");

    sweep_idx = 0;
    for (int s = 0; s < 4; s++) begin
      for (int mc = 0; mc < 8; mc++) begin
        for (int ml = 0; ml < 16; ml++) begin
          do_job(sweep_idx, s[1], s[0], mc, ml, ref_prod(s[1], s[0], mc, ml), "t6_sweep");
          sweep_idx = 1 - sweep_idx;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
